input_conditioner: RTL and testbench

//   Per-channel synchroniser, debouncer and edge detector for board switches and buttons.

---
 rtl/input_conditioner.sv | 138 +++++++++++++
 tb/tb_input_conditioner.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// Per-channel synchroniser, debouncer and rise/fall edge detector paced by a 1 ms enable.
// Optional auto-repeat strobes are built only when INPUT_COND_AUTOREPEAT_EN is defined.
module input_conditioner #(
  parameter int               WIDTH        = 9,
  parameter int               DB_MS        = 20,
  parameter logic [WIDTH-1:0] INV_MASK     = 9'h100,
  parameter int               RPT_DELAY_MS = 500,
  parameter int               RPT_RATE_MS  = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce1ms,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] rpt
);

  localparam int CW = $clog2(DB_MS + 1);

  typedef enum logic {STABLE, CHANGING} db_state_t;

  if (DB_MS < 1 || RPT_DELAY_MS < 1 || RPT_RATE_MS < 1) begin : g_bad_cfg
    $error("input_conditioner: DB_MS, RPT_DELAY_MS and RPT_RATE_MS must be >= 1");
  end

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;

  // Inversion happens before the synchroniser so every later stage sees 1 = active.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw ^ INV_MASK;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    db_state_t   state;
    logic [CW-1:0] cnt;
    logic        lvl_q;
    logic        rise_q;
    logic        fall_q;
    logic        accept;

    assign accept = (state == CHANGING) && (sync2[i] != lvl_q) && ce1ms &&
                    (cnt == CW'(DB_MS - 1));

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state  <= STABLE;
        cnt    <= '0;
        lvl_q  <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        case (state)
          STABLE: begin
            cnt <= '0;
            if (sync2[i] != lvl_q) state <= CHANGING;
          end
          CHANGING: begin
            if (sync2[i] == lvl_q) begin
              state <= STABLE;
              cnt   <= '0;
            end else if (accept) begin
              lvl_q  <= ~lvl_q;
              rise_q <= ~lvl_q;
              fall_q <= lvl_q;
              cnt    <= '0;
              state  <= STABLE;
            end else if (ce1ms) begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= STABLE;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign level[i] = lvl_q;
    assign rise[i]  = rise_q;
    assign fall[i]  = fall_q;

`ifdef INPUT_COND_AUTOREPEAT_EN
    localparam int RMAX = (RPT_DELAY_MS > RPT_RATE_MS) ? RPT_DELAY_MS : RPT_RATE_MS;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rcnt;
    logic          first;
    logic          rpt_q;

    // The first repeat waits the long delay; later ones use the shorter rate.
    // A tick that accepts a release never also produces a repeat.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rcnt  <= '0;
        first <= 1'b0;
        rpt_q <= 1'b0;
      end else begin
        rpt_q <= 1'b0;
        if (accept && !lvl_q) begin
          rpt_q <= 1'b1;
          rcnt  <= '0;
          first <= 1'b1;
        end else if (accept && lvl_q) begin
          rcnt  <= '0;
          first <= 1'b0;
        end else if (lvl_q && ce1ms) begin
          if (first ? (rcnt == RW'(RPT_DELAY_MS - 1)) : (rcnt == RW'(RPT_RATE_MS - 1))) begin
            rpt_q <= 1'b1;
            rcnt  <= '0;
            first <= 1'b0;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
      end
    end

    assign rpt[i] = rpt_q;
`endif
  end

`ifndef INPUT_COND_AUTOREPEAT_EN
  assign rpt = '0;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner with DB_MS=4, RPT_DELAY_MS=6, RPT_RATE_MS=3, ce1ms every 10 clk.
module tb_input_conditioner;

  localparam int W = 9;

  logic         clk   = 1'b0;
  logic         rst   = 1'b0;
  logic         ce1ms = 1'b0;
  logic [W-1:0] raw   = 9'h100;
  logic [W-1:0] level;
  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic [W-1:0] rpt;

  int errors  = 0;
  int checks  = 0;
  int phase   = 0;
  int tick_id = 0;

  typedef struct {
    int tick;
    int ch;
    int kind;
  } ev_t;

  ev_t sb[$];

  input_conditioner #(
    .WIDTH(9), .DB_MS(4), .INV_MASK(9'h100), .RPT_DELAY_MS(6), .RPT_RATE_MS(3)
  ) dut (
    .clk(clk), .rst(rst), .ce1ms(ce1ms), .raw(raw),
    .level(level), .rise(rise), .fall(fall), .rpt(rpt)
  );

  always #5 clk = ~clk;

  // One-cycle ce1ms every 10 clocks; tick_id numbers the tick about to be consumed.
  initial begin
    forever begin
      @(negedge clk);
      phase = (phase + 1) % 10;
      ce1ms = (phase == 0);
      if (ce1ms) tick_id++;
    end
  end

  // Every strobe pops the next expected event and must match its channel, kind and tick.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int c = 0; c < W; c++) begin
        for (int k = 0; k < 3; k++) begin
          logic hit;
          ev_t  e;
          hit = (k == 0) ? rise[c] : (k == 1) ? fall[c] : rpt[c];
          if (hit) begin
            checks++;
            if (sb.size() == 0) begin
              errors++;
              $display("[TB] FAIL unexpected_strobe: got kind=%0d ch=%0d tick=%0d, required none", k, c, tick_id);
            end else begin
              e = sb.pop_front();
              if (e.ch !== c || e.kind !== k || e.tick !== tick_id)
                begin
                  errors++;
                  $display("[TB] FAIL strobe: got kind=%0d ch=%0d tick=%0d, required kind=%0d ch=%0d tick=%0d",
                           k, c, tick_id, e.kind, e.ch, e.tick);
                end
            end
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic push(input int tick, input int ch, input int kind);
    ev_t e;
    e.tick = tick;
    e.ch   = ch;
    e.kind = kind;
    sb.push_back(e);
  endtask

  // Returns 2 ns after the posedge that consumes the next ce1ms tick.
  task automatic align();
    @(posedge clk);
    while (ce1ms !== 1'b1) @(posedge clk);
    #2;
  endtask

  task automatic wait_ticks(input int n);
    for (int t = 0; t < n; t++) align();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #2;
      raw = W'($urandom);
      checks++;
      if ({level, rise, fall, rpt} !== '0) begin
        errors++;
        $display("[TB] FAIL reset_outputs: got %h, required 0", {level, rise, fall, rpt});
      end
    end
    raw = 9'h100;
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
    checks++;
    if ({level, rise, fall, rpt} !== '0) begin
      errors++;
      $display("[TB] FAIL release_first_cycle: got %h, required 0", {level, rise, fall, rpt});
    end
    wait_ticks(5);
    checks++;
    if (level !== '0) begin
      errors++;
      $display("[TB] FAIL idle_level: got %h, required 0", level);
    end
  endtask

  task automatic test_debounce();
    int k;
    align();
    k = tick_id;
    raw[0] = 1'b1;
    push(k + 4, 0, 0);
    wait_ticks(3);
    checks++;
    if (level[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL debounce_early: got level0=%b, required 0", level[0]);
    end
    align();
    checks++;
    if (level[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL debounce_accept: got level0=%b, required 1", level[0]);
    end
    raw[0] = 1'b0;
    push(k + 8, 0, 1);
    wait_ticks(4);
    checks++;
    if (level[0] !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL debounce_release: got level0=%b pending=%0d, required 0 and 0", level[0], sb.size());
    end
  endtask

  task automatic test_glitch();
    align();
    raw[1] = 1'b1;
    wait_ticks(2);
    raw[1] = 1'b0;
    wait_ticks(4);
    checks++;
    if (level[1] !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL glitch: got level1=%b pending=%0d, required 0 and 0", level[1], sb.size());
    end
  endtask

  task automatic test_active_low();
    int k;
    align();
    k = tick_id;
    raw[8] = 1'b0;
    push(k + 4, 8, 0);
    wait_ticks(4);
    checks++;
    if (level[8] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL btn_press: got level8=%b, required 1", level[8]);
    end
    raw[8] = 1'b1;
    push(k + 8, 8, 1);
    wait_ticks(4);
    checks++;
    if (level[8] !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL btn_release: got level8=%b pending=%0d, required 0 and 0", level[8], sb.size());
    end
  endtask

  task automatic test_back_to_back();
    int k;
    align();
    k = tick_id;
    raw[0] = 1'b1;
    raw[5] = 1'b1;
    push(k + 4, 0, 0);
    push(k + 4, 5, 0);
    wait_ticks(4);
    checks++;
    if (level !== 9'h021) begin
      errors++;
      $display("[TB] FAIL simultaneous_level: got %h, required 021", level);
    end
    raw[0] = 1'b0;
    raw[5] = 1'b0;
    push(k + 8, 0, 1);
    push(k + 8, 5, 1);
    wait_ticks(4);
    checks++;
    if (level !== '0 || sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL simultaneous_release: got level=%h pending=%0d, required 0 and 0", level, sb.size());
    end
  endtask

  task automatic test_reset_mid_count();
    int k;
    align();
    raw[3] = 1'b1;
    wait_ticks(2);
    rst = 1'b0;
    wait_ticks(3);
    checks++;
    if (level[3] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_count_reset: got level3=%b, required 0", level[3]);
    end
    k = tick_id;
    rst = 1'b1;
    push(k + 4, 3, 0);
    @(posedge clk);
    #2;
    checks++;
    if ({level, rise, fall, rpt} !== '0) begin
      errors++;
      $display("[TB] FAIL release_pin_active: got %h, required 0", {level, rise, fall, rpt});
    end
    wait_ticks(4);
    checks++;
    if (level[3] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL late_rise: got level3=%b, required 1", level[3]);
    end
    raw[3] = 1'b0;
    push(k + 8, 3, 1);
    wait_ticks(4);
    checks++;
    if (level[3] !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL late_release: got level3=%b pending=%0d, required 0 and 0", level[3], sb.size());
    end
  endtask

  task automatic test_autorepeat();
    int k;
    align();
    k = tick_id;
    raw[2] = 1'b1;
    push(k + 4, 2, 0);
`ifdef INPUT_COND_AUTOREPEAT_EN
    push(k + 4, 2, 2);
    for (int r = k + 10; r < k + 24; r += 3) push(r, 2, 2);
`endif
    for (int t = 0; t < 20; t++) begin
      align();
`ifndef INPUT_COND_AUTOREPEAT_EN
      checks++;
      if (rpt !== '0) begin
        errors++;
        $display("[TB] FAIL rpt_off: got %h, required 0", rpt);
      end
`endif
    end
    raw[2] = 1'b0;
    push(k + 24, 2, 1);
    wait_ticks(4);
    checks++;
    if (level[2] !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL autorepeat_end: got level2=%b pending=%0d, required 0 and 0", level[2], sb.size());
    end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_debounce();
    test_glitch();
    test_active_low();
    test_back_to_back();
    test_reset_mid_count();
    test_autorepeat();
    wait_ticks(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
